keypad_entry_ctrl: RTL
======================

Name: keypad_entry_ctrl

Overview:
- Sequences keypad digit entry into the 8-slot 4-bit register bank.
- Takes the encoder's BCD digit and key-valid bit, then synchronizes, debounces and edge-qualifies each press.
- Writes each accepted digit into the next free slot via one-hot write enables and tracks fill level.
- Provides a clear command that empties the bank and restarts entry at slot 0.

Parameters:
- NSLOTS, 8, number of register slots driven (one wr_en bit each).
- DEBOUNCE, 2, consecutive stable synchronized cycles required to accept a press or release (>=1).
- CW, 4, width of digit_count (must hold 0..NSLOTS).

Ports:
- clk  input  1  system clock, rising edge.
- rst_ui  input  1  asynchronous active-low reset.
- key_valid  input  1  key-pressed flag from the input encoder (asynchronous to clk).
- key_bcd  input  4  BCD digit from the input encoder, valid while key_valid=1.
- clear  input  1  synchronous clear request (clk-domain level); highest priority.
- wr_en  output  NSLOTS  one-hot slot write strobe, one cycle wide.
- wr_data  output  4  digit to write; stable while any wr_en bit is high.
- digit_count  output  CW  number of slots filled (0..NSLOTS).
- full  output  1  high when digit_count==NSLOTS.
- overflow  output  1  one-cycle pulse when a press is accepted while full.
- bad_digit  output  1  one-cycle pulse when an accepted press has key_bcd>9.
- clr_regs  output  1  one-cycle pulse commanding the register bank to clear.

Behaviour:
- Reset (rst_ui=0, asynchronous):
  - State goes to IDLE; synchronizer flops, debounce counter and write pointer go to 0.
  - All outputs are 0: wr_en=0, wr_data=0, digit_count=0, full=0, and all pulses 0.
  - Reset asserted mid-press aborts the press with no write. After release, a still-held key is treated as a new press.
- Synchronizer: key_valid and key_bcd each pass through 2 flops, producing kv_s and kb_s. The FSM uses only kv_s and kb_s.
- States: IDLE, DB_PRESS, WRITE, WAIT_REL, DB_REL.
- IDLE: if kv_s=1, capture kb_s into the digit register, set cnt=0 and go to DB_PRESS.
- DB_PRESS:
  - If kv_s=0 or kb_s differs from the captured digit, treat it as a bounce and return to IDLE with no write.
  - Else if cnt==DEBOUNCE-1, go to WRITE.
  - Else increment cnt.
- WRITE lasts exactly one cycle; all outputs below are Moore outputs registered from the state. Exactly one of the following occurs:
  - Digit >9: pulse bad_digit; no write.
  - Digit <=9 and full: pulse overflow; no write.
  - Otherwise: wr_en[ptr]=1, wr_data=digit, then ptr and digit_count increment.
  - In every case the next state is WAIT_REL.
- WAIT_REL: if kv_s=0, set cnt=0 and go to DB_REL.
- DB_REL:
  - If kv_s=1, return to WAIT_REL; a release glitch never produces a second write.
  - Else if cnt==DEBOUNCE-1, go to IDLE.
  - Else increment cnt.
- Latency: the first write strobe is high in the cycle after rising edge 3+DEBOUNCE, counted from key_valid going high and staying stable.
- Throughput: at most one write per press-release cycle; a held key writes once.
- Pointer: ptr equals digit_count. There is no wrap-around, and full saturates until clear.
- Clear (clear=1 on an edge):
  - Overrides every state, including WRITE (the pending write is dropped).
  - Sets ptr=0 and digit_count=0, and pulses clr_regs for one cycle.
  - Next state is WAIT_REL if kv_s=1, else IDLE.
  - Clear held for multiple cycles keeps counters at 0 and produces one clr_regs pulse per cycle asserted.
  - Clear and a press in the same cycle: clear wins and the press is discarded.
- full is combinational from digit_count==NSLOTS and is 0 during reset.
- clr_regs is never asserted together with wr_en.

Test Plan:
- Reset, then press key 5 stable for 10 cycles and release; DEBOUNCE=2 → wr_en=8'b00000001 and wr_data=5 for exactly one cycle after edge 5; digit_count=1; no further strobes while the key is held.
- Enter 2,1,9,3,5,4,8,8 with clean press/release each → wr_en walks bit0..bit7 with the matching wr_data; digit_count=8, full=1. A ninth press of 7 → overflow pulse, no wr_en, count stays 8.
- Bounce: key_valid high 1 cycle, low, high 1 cycle, then stable → only one write. Release glitch (low 1 cycle, high 1 cycle, low) → no second write.
- Press with key_bcd=4'b1100 stable → bad_digit pulse, no wr_en, digit_count unchanged.
- With count=3, assert clear for 1 cycle while key 6 is held → clr_regs pulse, count=0, no write. Release then press 6 → wr_en[0] with data 6.
- Drop rst_ui low during DB_PRESS with count=2 → all outputs 0 immediately; after rst_ui rises with the key still held, the press is taken as new and written to slot 0.

Source files
------------

// File: rtl/keypad_entry_ctrl_if.sv
// keypad_entry_ctrl_if: encoder-side inputs and register-bank-side outputs of the keypad entry controller
interface keypad_entry_ctrl_if #(
  parameter int NSLOTS = 8,
  parameter int CW     = 4
);
  logic              key_valid;
  logic [3:0]        key_bcd;
  logic              clear;
  logic [NSLOTS-1:0] wr_en;
  logic [3:0]        wr_data;
  logic [CW-1:0]     digit_count;
  logic              full;
  logic              overflow;
  logic              bad_digit;
  logic              clr_regs;
  modport master (
    input  key_valid, key_bcd, clear,
    output wr_en, wr_data, digit_count, full, overflow, bad_digit, clr_regs
  );
  modport slave (
    output key_valid, key_bcd, clear,
    input  wr_en, wr_data, digit_count, full, overflow, bad_digit, clr_regs
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: synchronizes, debounces and edge-qualifies key presses into one-hot slot writes
module keypad_entry_ctrl #(
  parameter int NSLOTS   = 8,
  parameter int DEBOUNCE = 2,
  parameter int CW       = 4
) (
  input  logic                 clk,
  input  logic                 rst_ui,
  keypad_entry_ctrl_if.master  bus
);
  localparam int DCW = $clog2(DEBOUNCE) + 1;
  typedef enum logic [2:0] {IDLE, DB_PRESS, WRITE, WAIT_REL, DB_REL} state_t;
  state_t            state_q, state_d;
  logic [1:0]        kv_q;
  logic [3:0]        kb1_q, kb2_q;
  logic [DCW-1:0]    cnt_q, cnt_d;
  logic [3:0]        digit_q, digit_d;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic [NSLOTS-1:0] wr_en_q, wr_en_d;
  logic [3:0]        wr_data_q, wr_data_d;
  logic              ovf_q, ovf_d, bad_q, bad_d, clr_q, clr_d;
  logic              kv_s, full, last;
  logic [3:0]        kb_s;
  assign kv_s = kv_q[1];
  assign kb_s = kb2_q;
  assign full = ptr_q == CW'(NSLOTS);
  assign last = cnt_q == DCW'(DEBOUNCE - 1);
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    digit_d   = digit_q;
    ptr_d     = ptr_q;
    wr_en_d   = '0;
    wr_data_d = wr_data_q;
    ovf_d     = 1'b0;
    bad_d     = 1'b0;
    clr_d     = 1'b0;
    case (state_q)
      IDLE:     if (kv_s) begin digit_d = kb_s; cnt_d = '0; state_d = DB_PRESS; end
      DB_PRESS: if (!kv_s || kb_s != digit_q) state_d = IDLE;
                else if (last) state_d = WRITE;
                else cnt_d = cnt_q + 1'b1;
      WRITE:    begin ptr_d = ptr_q + CW'(|wr_en_q); state_d = WAIT_REL; end
      WAIT_REL: if (!kv_s) begin cnt_d = '0; state_d = DB_REL; end
      DB_REL:   if (kv_s) state_d = WAIT_REL;
                else if (last) state_d = IDLE;
                else cnt_d = cnt_q + 1'b1;
      default:  state_d = IDLE;
    endcase
    // WRITE-state outputs are decided on the edge entering WRITE so they are registered Moore outputs
    if (state_q == DB_PRESS && state_d == WRITE) begin
      bad_d     = digit_q > 4'd9;
      ovf_d     = !bad_d && full;
      wr_en_d   = (bad_d || ovf_d) ? '0 : NSLOTS'(1) << ptr_q;
      wr_data_d = (bad_d || ovf_d) ? wr_data_q : digit_q;
    end
    if (bus.clear) begin
      state_d = kv_s ? WAIT_REL : IDLE;
      cnt_d   = '0;
      ptr_d   = '0;
      wr_en_d = '0;
      ovf_d   = 1'b0;
      bad_d   = 1'b0;
      clr_d   = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_ui) begin
    if (!rst_ui) begin
      state_q   <= IDLE;
      kv_q      <= '0;
      kb1_q     <= '0;
      kb2_q     <= '0;
      cnt_q     <= '0;
      digit_q   <= '0;
      ptr_q     <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
      bad_q     <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      kv_q      <= {kv_q[0], bus.key_valid};
      kb1_q     <= bus.key_bcd;
      kb2_q     <= kb1_q;
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      ovf_q     <= ovf_d;
      bad_q     <= bad_d;
      clr_q     <= clr_d;
    end
  end
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.digit_count = ptr_q;
  assign bus.full        = full;
  assign bus.overflow    = ovf_q;
  assign bus.bad_digit   = bad_q;
  assign bus.clr_regs    = clr_q;
endmodule
